// File: rtl/ebox_mbox_arb_pkg.sv
// Shared types and defaults for the multi-channel EBOX->MBOX reference arbiter.
package ebox_arb_pkg;

    localparam int DEF_NCH      = 4;
    localparam int DEF_ADRW     = 23;
    localparam int DEF_MAXRETRY = 7;
    localparam int DEF_TMO      = 255;
    localparam int DEF_PRI0     = 1;

    // Widest address and channel index the holding register can carry.
    localparam int MAX_ADRW = 36;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 36;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF,
        DONE
    } arb_state_e;

    // Reference latched at grant and held until completion.
    typedef struct packed {
        logic [MAX_ADRW-1:0] adr;
        logic                write;
        logic [DATA_W-1:0]   wdata;
        logic [IDX_W-1:0]    idx;
    } ref_t;

    // Width of a counter that must reach maxval; never narrower than one bit.
    function automatic int cnt_w(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/ebox_mbox_arb_if.sv
// MBOX request/response port: master is the arbiter, slave is the MBOX.
interface ebox_mbox_arb_if
    import ebox_arb_pkg::*;
#(
    parameter int ADRW = DEF_ADRW
);
    logic              EBOX_REQ;
    logic [ADRW-1:0]   EBOX_VMA;
    logic              eboxRead;
    logic              eboxWrite;
    logic [DATA_W-1:0] cacheDataWrite;
    logic              mboxRespIn;
    logic              cshEBOXRetry;
    logic [DATA_W-1:0] cacheDataRead;

    modport master (
        output EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        input  mboxRespIn, cshEBOXRetry, cacheDataRead
    );

    modport slave (
        input  EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        output mboxRespIn, cshEBOXRetry, cacheDataRead
    );
endinterface

// File: rtl/ebox_mbox_arb_rr_pick.sv
// Combinational winner selection: optional fixed priority for channel 0,
// otherwise the first requester at or after ptr, wrapping modulo NCH.
module rr_pick
    import ebox_arb_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    localparam int PW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    input  logic           PRI0,
    output logic [PW-1:0]  idx,
    output logic           any
);

    // Walk the ring from farthest to nearest so the nearest requester is written last.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional value first so no latch is inferred.
        idx = '0;
        any = |req;
        if (!(PRI0 && req[0])) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % NCH]) begin
                    idx = PW'((int'(ptr) + k) % NCH);
                end
            end
        end
    end

endmodule

// File: rtl/ebox_mbox_arb.sv
// Arbitrates NCH requestors onto the single MBOX request port, handling
// MBOX retry with backoff, response timeout (NXM) and per-channel completion.
module ebox_mbox_arb
    import ebox_arb_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int ADRW     = DEF_ADRW,
    parameter int MAXRETRY = DEF_MAXRETRY,
    parameter int TMO      = DEF_TMO,
    parameter bit PRI0     = 1'(DEF_PRI0)
) (
    input  logic                        clk,
    input  logic                        CROBAR,
    input  logic [NCH-1:0]              chReq,
    input  logic [NCH-1:0]              chWrite,
    input  logic [NCH-1:0][ADRW-1:0]    chAdr,
    input  logic [NCH-1:0][DATA_W-1:0]  chWData,
    output logic [NCH-1:0]              chDone,
    output logic [NCH-1:0]              chErr,
    output logic [DATA_W-1:0]           rData,
    output logic                        busy,
    ebox_mbox_arb_if.master             mbox
);

    localparam int PW = $clog2(NCH);
    localparam int RW = cnt_w(MAXRETRY);
    localparam int TW = cnt_w(TMO);

    arb_state_e        state_q;
    ref_t              ref_q;
    logic [PW-1:0]     rr_ptr_q;
    logic              pri_win_q;
    logic [RW-1:0]     retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              ebox_req_q, ebox_read_q, ebox_write_q, busy_q;
    logic [NCH-1:0]    ch_done_q, ch_err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [NCH-1:0]    done_vec;
    logic [PW-1:0]     next_ptr;

    rr_pick #(.NCH(NCH)) u_pick (
        .req  (chReq),
        .ptr  (rr_ptr_q),
        .PRI0 (PRI0),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign done_vec = NCH'(1) << ref_q.idx;
    assign next_ptr = PW'((ref_q.idx == IDX_W'(NCH - 1)) ? '0 : ref_q.idx + IDX_W'(1));

    // Saturating next values for the retry and timeout counters.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        if (tmo_cnt_q != TW'(TMO)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        if (retry_cnt_q != RW'(MAXRETRY)) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
        end
    end

    // Reference FSM with its counters, holding register and registered outputs.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            // NOTE: the holding register is reset too, so every output is 0 out of reset.
            state_q      <= IDLE;
            ref_q        <= '0;
            rr_ptr_q     <= '0;
            pri_win_q    <= 1'b0;
            retry_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            ebox_req_q   <= 1'b0;
            ebox_read_q  <= 1'b0;
            ebox_write_q <= 1'b0;
            busy_q       <= 1'b0;
            ch_done_q    <= '0;
            ch_err_q     <= '0;
            rdata_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            ch_done_q <= '0;
            ch_err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        ref_q.adr    <= MAX_ADRW'(chAdr[pick_idx]);
                        ref_q.write  <= chWrite[pick_idx];
                        ref_q.wdata  <= chWData[pick_idx];
                        ref_q.idx    <= IDX_W'(pick_idx);
                        pri_win_q    <= PRI0 && chReq[0];
                        retry_cnt_q  <= '0;
                        tmo_cnt_q    <= '0;
                        ebox_req_q   <= 1'b1;
                        ebox_read_q  <= !chWrite[pick_idx];
                        ebox_write_q <= chWrite[pick_idx];
                        busy_q       <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    if (mbox.mboxRespIn) begin
                        if (!ref_q.write) begin
                            rdata_q <= mbox.cacheDataRead;
                        end
                        ebox_req_q <= 1'b0;
                        ch_done_q  <= done_vec;
                        state_q    <= DONE;
                    end else if (mbox.cshEBOXRetry) begin
                        ebox_req_q <= 1'b0;
                        if (retry_cnt_q == RW'(MAXRETRY)) begin
                            ch_done_q <= done_vec;
                            ch_err_q  <= done_vec;
                            state_q   <= DONE;
                        end else begin
                            retry_cnt_q <= retry_cnt_d;
                            tmo_cnt_q   <= '0;
                            state_q     <= BACKOFF;
                        end
                    end else if (tmo_cnt_q == TW'(TMO)) begin
                        ebox_req_q <= 1'b0;
                        ch_done_q  <= done_vec;
                        ch_err_q   <= done_vec;
                        state_q    <= DONE;
                    end
                end
                BACKOFF: begin
                    ebox_req_q <= 1'b1;
                    state_q    <= REQ;
                end
                DONE: begin
                    if (!pri_win_q) begin
                        rr_ptr_q <= next_ptr;
                    end
                    ebox_read_q  <= 1'b0;
                    ebox_write_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mbox.EBOX_REQ       = ebox_req_q;
    assign mbox.EBOX_VMA       = ADRW'(ref_q.adr);
    assign mbox.eboxRead       = ebox_read_q;
    assign mbox.eboxWrite      = ebox_write_q;
    assign mbox.cacheDataWrite = ref_q.wdata;
    assign chDone              = ch_done_q;
    assign chErr               = ch_err_q;
    assign rData               = rdata_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_ebox_mbox_arb.sv
// Scoreboard bench: dut0 (round-robin) gets directed and random batches with a
// randomized MBOX responder; dut1 (channel 0 priority) gets the starvation sequence.
module tb_ebox_mbox_arb;

    localparam int NCH  = 4;
    localparam int ADRW = 23;
    localparam int MAXR = 2;
    localparam int TMO  = 10;

    typedef struct {
        int          idx;
        bit          write;
        logic [22:0] adr;
        logic [35:0] wdata;
        logic [35:0] rdata;
        int          retries;
        bit          tmo;
        int          dly;
        bit          err;
    } ref_s;

    logic clk;
    logic crobar;

    logic [3:0]        chReq0, chWrite0, chDone0, chErr0;
    logic [3:0][22:0]  chAdr0;
    logic [3:0][35:0]  chWData0;
    logic [35:0]       rData0;
    logic              busy0;

    logic [3:0]        chReq1, chWrite1, chDone1, chErr1;
    logic [3:0][22:0]  chAdr1;
    logic [3:0][35:0]  chWData1;
    logic [35:0]       rData1;
    logic              busy1;

    ebox_mbox_arb_if #(.ADRW(ADRW)) mb0 ();
    ebox_mbox_arb_if #(.ADRW(ADRW)) mb1 ();

    ebox_mbox_arb #(.NCH(NCH), .ADRW(ADRW), .MAXRETRY(MAXR), .TMO(TMO), .PRI0(1'b0)) dut0 (
        .clk(clk), .CROBAR(crobar), .chReq(chReq0), .chWrite(chWrite0), .chAdr(chAdr0),
        .chWData(chWData0), .chDone(chDone0), .chErr(chErr0), .rData(rData0), .busy(busy0),
        .mbox(mb0)
    );

    ebox_mbox_arb #(.NCH(NCH), .ADRW(ADRW), .MAXRETRY(MAXR), .TMO(TMO), .PRI0(1'b1)) dut1 (
        .clk(clk), .CROBAR(crobar), .chReq(chReq1), .chWrite(chWrite1), .chAdr(chAdr1),
        .chWData(chWData1), .chDone(chDone1), .chErr(chErr1), .rData(rData1), .busy(busy1),
        .mbox(mb1)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    ref_s exp0_q[$];
    ref_s act0_q[$];
    int   exp1_q[$];
    ref_s plan[NCH];
    int   model_ptr;
    bit   resp_en;
    int   hold0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_fields(input ref_s p);
        check("vma", 64'(mb0.EBOX_VMA), 64'(p.adr));
        check("ebox_read", 64'(mb0.eboxRead), 64'(!p.write));
        check("ebox_write", 64'(mb0.eboxWrite), 64'(p.write));
        if (p.write) check("wdata", 64'(mb0.cacheDataWrite), 64'(p.wdata));
    endtask

    function automatic ref_s rand_plan(input int ch);
        ref_s p;
        p.idx     = ch;
        p.write   = 1'($urandom_range(0, 1));
        p.adr     = 23'($urandom);
        p.wdata   = {4'($urandom_range(0, 15)), 32'($urandom)};
        p.rdata   = {4'($urandom_range(0, 15)), 32'($urandom)};
        p.retries = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        p.tmo     = ($urandom_range(0, 5) == 0);
        p.dly     = int'($urandom_range(0, 3));
        p.err     = 1'b0;
        return p;
    endfunction

    // Service order: repeatedly the first requester at/after the pointer; pointer moves past it.
    task automatic issue_batch(input logic [3:0] mask);
        logic [3:0] rem;
        int j;
        ref_s p;
        rem = mask;
        while (rem != 0) begin
            j = model_ptr;
            while (!rem[j]) j = (j + 1) % NCH;
            p = plan[j];
            p.err = (p.retries > MAXR) || p.tmo;
            exp0_q.push_back(p);
            act0_q.push_back(p);
            rem[j] = 1'b0;
            model_ptr = (j + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                chAdr0[c]   = plan[c].adr;
                chWData0[c] = plan[c].wdata;
                chWrite0[c] = plan[c].write;
            end
        end
        chReq0 = chReq0 | mask;
        @(negedge clk);
        check("grant_latency", 64'(mb0.EBOX_REQ), 64'd1);
    endtask

    task automatic drain(input bit which);
        int budget;
        budget = 0;
        while (((which ? exp1_q.size() : exp0_q.size()) != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check(which ? "drain_dut1" : "drain_dut0", 64'(which ? exp1_q.size() : exp0_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // dut0 MBOX responder: plays out each reference's retry/response/timeout plan.
    initial begin : resp0
        ref_s p;
        int budget;
        mb0.mboxRespIn    = 1'b0;
        mb0.cshEBOXRetry  = 1'b0;
        mb0.cacheDataRead = '0;
        forever begin
            @(negedge clk);
            if (resp_en && mb0.EBOX_REQ && act0_q.size() > 0) begin
                p = act0_q.pop_front();
                check_fields(p);
                chAdr0[p.idx]   = 23'($urandom);
                chWData0[p.idx] = {4'($urandom_range(0, 15)), 32'($urandom)};
                if ($urandom_range(0, 3) == 0) chReq0[p.idx] = 1'b0;
                for (int r = 0; r < p.retries && r <= MAXR; r++) begin
                    repeat (p.dly) @(negedge clk);
                    mb0.cshEBOXRetry = 1'b1;
                    @(negedge clk);
                    mb0.cshEBOXRetry = 1'b0;
                    if (r < MAXR) begin
                        check("backoff_gap", 64'(mb0.EBOX_REQ), 64'd0);
                        @(negedge clk);
                        check("req_after_backoff", 64'(mb0.EBOX_REQ), 64'd1);
                        check_fields(p);
                    end
                end
                if (p.retries <= MAXR && !p.tmo) begin
                    repeat (p.dly) @(negedge clk);
                    check_fields(p);
                    mb0.cacheDataRead = p.rdata;
                    mb0.mboxRespIn    = 1'b1;
                    @(negedge clk);
                    mb0.mboxRespIn    = 1'b0;
                    mb0.cacheDataRead = ~p.rdata;
                end
                budget = 0;
                while (chDone0 == 0 && budget < 40) begin
                    @(negedge clk);
                    budget++;
                end
                check("completion_seen", 64'(chDone0 != 0), 64'd1);
            end
        end
    end

    // dut0 monitor: pops the scoreboard on every completion and checks timing.
    initial begin : mon0
        ref_s e;
        int   mcyc;
        int   rise_cyc;
        int   want_rise;
        bit   req_prev;
        mcyc = 0; rise_cyc = 0; want_rise = -1; req_prev = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (mb0.EBOX_REQ && !req_prev) begin
                rise_cyc = mcyc;
                if (want_rise >= 0) check("regrant_latency", 64'(mcyc), 64'(want_rise));
                want_rise = -1;
            end
            req_prev = mb0.EBOX_REQ;
            if (chDone0 != 0) begin
                if (exp0_q.size() == 0) begin
                    check("unexpected_done", 64'(chDone0), 64'd0);
                end else begin
                    e = exp0_q.pop_front();
                    check("done_idx", 64'(chDone0), 64'(4'b1 << e.idx));
                    check("done_err", 64'(chErr0), e.err ? 64'(4'b1 << e.idx) : 64'd0);
                    if (!e.write && !e.err) check("rdata", 64'(rData0), 64'(e.rdata));
                    if (e.tmo && e.retries <= MAXR) check("tmo_latency", 64'(mcyc - rise_cyc), 64'(TMO + 1));
                    chReq0[e.idx] = 1'b0;
                    if (exp0_q.size() > 0) want_rise = mcyc + 2;
                end
            end
        end
    end

    // dut1 MBOX: answers every request in its first cycle.
    initial begin : resp1
        mb1.mboxRespIn    = 1'b0;
        mb1.cshEBOXRetry  = 1'b0;
        mb1.cacheDataRead = '0;
        forever begin
            @(negedge clk);
            mb1.mboxRespIn = mb1.EBOX_REQ && !mb1.mboxRespIn;
        end
    end

    // dut1 monitor: grant order, with channel 0 optionally re-requesting.
    initial begin : mon1
        int e;
        forever begin
            @(negedge clk);
            if (chDone1 != 0) begin
                if (exp1_q.size() == 0) begin
                    check("dut1_unexpected_done", 64'(chDone1), 64'd0);
                end else begin
                    e = exp1_q.pop_front();
                    check("dut1_grant_order", 64'(chDone1), 64'(4'b1 << e));
                    check("dut1_err", 64'(chErr1), 64'd0);
                    if (e == 0 && hold0 > 0) hold0--;
                    else chReq1[e] = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin : main
        crobar = 1'b1;
        chReq0 = '0; chWrite0 = '0; chAdr0 = '0; chWData0 = '0;
        chReq1 = '0; chWrite1 = 4'hF; chWData1 = '0;
        for (int c = 0; c < NCH; c++) chAdr1[c] = 23'(c);
        resp_en = 1'b1; model_ptr = 0; hold0 = 0;
        repeat (3) @(negedge clk);
        check("rst_ebox_req", 64'(mb0.EBOX_REQ), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'({chDone0, chErr0, chDone1}), 64'd0);
        check("rst_rdata", 64'(rData0), 64'd0);
        check("rst_vma_type", 64'({mb0.EBOX_VMA, mb0.eboxRead, mb0.eboxWrite}), 64'd0);
        crobar = 1'b0;
        @(negedge clk);

        // Round robin from pointer 0: all four, then channel 0 again after the wrap.
        for (int c = 0; c < NCH; c++) plan[c] = rand_plan(c);
        issue_batch(4'b1111);
        drain(1'b0);
        plan[0] = rand_plan(0);
        issue_batch(4'b0001);
        drain(1'b0);

        // Single read on channel 2.
        plan[2] = '{idx: 2, write: 1'b0, adr: 23'o1234, wdata: '0, rdata: 36'o777000111222,
                    retries: 0, tmo: 1'b0, dly: 0, err: 1'b0};
        issue_batch(4'b0100);
        drain(1'b0);

        // Retry exhaustion, retries then success, and a timeout.
        plan[1] = rand_plan(1); plan[1].retries = 3; plan[1].tmo = 1'b0; plan[1].dly = 0;
        issue_batch(4'b0010);
        drain(1'b0);
        plan[1] = rand_plan(1); plan[1].retries = 2; plan[1].tmo = 1'b0; plan[1].write = 1'b0;
        issue_batch(4'b0010);
        drain(1'b0);
        plan[3] = rand_plan(3); plan[3].retries = 0; plan[3].tmo = 1'b1;
        issue_batch(4'b1000);
        drain(1'b0);

        // Random batches.
        for (int b = 0; b < 30; b++) begin
            for (int c = 0; c < NCH; c++) plan[c] = rand_plan(c);
            issue_batch(4'($urandom_range(1, 15)));
            drain(1'b0);
        end

        // Park the pointer at 3, then reset with a reference in flight.
        plan[2] = rand_plan(2); plan[2].retries = 0; plan[2].tmo = 1'b0;
        issue_batch(4'b0100);
        drain(1'b0);
        resp_en = 1'b0;
        chAdr0[3] = 23'h5A5A5; chWrite0[3] = 1'b1;
        chReq0 = 4'b1000;
        @(negedge clk);
        check("inflight_before_reset", 64'(mb0.EBOX_REQ), 64'd1);
        repeat (2) @(negedge clk);
        crobar = 1'b1;
        chReq0 = '0;
        @(negedge clk);
        crobar = 1'b0;
        check("reset_ebox_req", 64'(mb0.EBOX_REQ), 64'd0);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_no_done", 64'(chDone0), 64'd0);
        repeat (3) @(negedge clk);
        check("reset_stays_idle", 64'({mb0.EBOX_REQ, chDone0}), 64'd0);
        resp_en = 1'b1;
        model_ptr = 0;
        for (int c = 0; c < NCH; c++) plan[c] = rand_plan(c);
        issue_batch(4'b1010);
        drain(1'b0);

        // dut1: channel 0 override does not move the pointer; channel 0 starves channel 3.
        exp1_q.push_back(2);
        chReq1 = 4'b0100;
        drain(1'b1);
        exp1_q.push_back(0);
        chReq1 = 4'b0001;
        drain(1'b1);
        exp1_q.push_back(3);
        exp1_q.push_back(1);
        chReq1 = 4'b1010;
        drain(1'b1);
        hold0 = 2;
        exp1_q.push_back(0);
        exp1_q.push_back(0);
        exp1_q.push_back(0);
        exp1_q.push_back(3);
        chReq1 = 4'b1001;
        drain(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
